// File: rtl/nts_dispatch_scheduler.sv
// Purpose  : shares one packet dispatcher between ENGINES engines. Each packet
//            goes round-robin to the first free engine; if none frees up
//            within TIMEOUT cycles the packet is discarded.
// Latency  : a granted engine sees packet_available two cycles after the IDLE
//            cycle that sees the packet; read/discard strobes pass through
//            combinationally while granted.
// Backpress: the dispatcher is held while every engine is busy. Only the granted
//            engine drives the dispatcher FIFO. A one-cycle HOLDOFF after each
//            packet lets the dispatcher refresh its packet-available flag.
//
// Ports
//   i_clk, i_areset_n                 clock, async active-low reset
//   i_dispatch_packet_available       dispatcher holds a complete packet
//   i_dispatch_fifo_empty             dispatcher FIFO empty
//   i_dispatch_data_valid[7:0]        byte-valid mask of the last word
//   i_dispatch_fifo_rd_data[63:0]     dispatcher FIFO read data
//   o_dispatch_fifo_rd_en             read strobe to the dispatcher
//   o_dispatch_packet_read_discard    one-cycle packet release pulse
//   i_engine_busy[E]                  per-engine busy flag
//   o_engine_packet_available[E]      per-engine packet-available flag
//   o_engine_fifo_empty[E]            per-engine FIFO-empty flag
//   i_engine_fifo_rd_en[E]            per-engine FIFO read strobe
//   i_engine_packet_read_discard[E]   per-engine packet-done pulse
//   o_engine_data_valid[7:0]          broadcast of i_dispatch_data_valid
//   o_engine_fifo_rd_data[63:0]       broadcast of i_dispatch_fifo_rd_data
//   o_busy                            scheduler not IDLE
//   o_dispatched_count[31:0]          packets granted to engines
//   o_dropped_count[31:0]             packets discarded on timeout
module nts_dispatch_scheduler #(
  parameter int ENGINES = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic               i_clk,
  input  logic               i_areset_n,
  input  logic               i_dispatch_packet_available,
  input  logic               i_dispatch_fifo_empty,
  input  logic [7:0]         i_dispatch_data_valid,
  input  logic [63:0]        i_dispatch_fifo_rd_data,
  output logic               o_dispatch_fifo_rd_en,
  output logic               o_dispatch_packet_read_discard,
  input  logic [ENGINES-1:0] i_engine_busy,
  output logic [ENGINES-1:0] o_engine_packet_available,
  output logic [ENGINES-1:0] o_engine_fifo_empty,
  input  logic [ENGINES-1:0] i_engine_fifo_rd_en,
  input  logic [ENGINES-1:0] i_engine_packet_read_discard,
  output logic [7:0]         o_engine_data_valid,
  output logic [63:0]        o_engine_fifo_rd_data,
  output logic               o_busy,
  output logic [31:0]        o_dispatched_count,
  output logic [31:0]        o_dropped_count
);

  localparam int PTR_W = $clog2(ENGINES);
  localparam int SUM_W = PTR_W + 1;
  localparam logic [SUM_W-1:0]   ENG_N    = SUM_W'(ENGINES);
  localparam logic [PTR_W-1:0]   LAST_ENG = PTR_W'(ENGINES - 1);
  localparam logic [15:0]        TO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [ENGINES-1:0] ONE_HOT0 = ENGINES'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_GRANT,
    ST_DISCARD,
    ST_HOLDOFF
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [15:0]        wait_cnt;
  // Latched grant, kept one-hot: it is directly the packet_available vector and
  // gates the pass-through strobes. All-zero outside GRANT.
  logic [ENGINES-1:0] gnt_oh;
  logic               drop_pulse;
  logic               busy_q;
  logic [31:0]        disp_cnt;
  logic [31:0]        drop_cnt;

  // Round-robin search: first non-busy engine at or after rr_ptr, wrapping.
  logic               found;
  logic [PTR_W-1:0]   pick;
  logic [SUM_W-1:0]   rr_sum;

  always_comb begin
    found  = 1'b0;
    pick   = '0;
    rr_sum = '0;
    for (int i = 0; i < ENGINES; i++) begin
      rr_sum = {1'b0, rr_ptr} + SUM_W'(i);
      if (rr_sum >= ENG_N) begin
        rr_sum = rr_sum - ENG_N;
      end
      if (!found && !i_engine_busy[rr_sum[PTR_W-1:0]]) begin
        found = 1'b1;
        pick  = rr_sum[PTR_W-1:0];
      end
    end
  end

  logic [PTR_W-1:0] rr_next;
  assign rr_next = (pick == LAST_ENG) ? '0 : pick + PTR_W'(1);

  // Granted engine's done pulse; busy of the granted engine is not looked at.
  logic gnt_done;
  assign gnt_done = |(gnt_oh & i_engine_packet_read_discard);

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      wait_cnt   <= '0;
      gnt_oh     <= '0;
      drop_pulse <= 1'b0;
      busy_q     <= 1'b0;
      disp_cnt   <= '0;
      drop_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_dispatch_packet_available && !i_dispatch_fifo_empty) begin
            state    <= ST_SELECT;
            wait_cnt <= '0;
            busy_q   <= 1'b1;
          end
        end
        ST_SELECT: begin
          if (found) begin
            gnt_oh   <= ONE_HOT0 << pick;
            rr_ptr   <= rr_next;
            disp_cnt <= disp_cnt + 32'd1;
            state    <= ST_GRANT;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
            // Compared before the increment: SELECT lasts TIMEOUT cycles.
            if (wait_cnt == TO_LAST) begin
              drop_pulse <= 1'b1;
              state      <= ST_DISCARD;
            end
          end
        end
        ST_GRANT: begin
          // Engine done and packet gone in the same cycle is one exit.
          if (gnt_done || !i_dispatch_packet_available) begin
            gnt_oh <= '0;
            state  <= ST_HOLDOFF;
          end
        end
        ST_DISCARD: begin
          drop_pulse <= 1'b0;
          drop_cnt   <= drop_cnt + 32'd1;
          state      <= ST_HOLDOFF;
        end
        ST_HOLDOFF: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          gnt_oh     <= '0;
          drop_pulse <= 1'b0;
          busy_q     <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

  // Non-granted engines always see no packet and an empty FIFO.
  assign o_engine_packet_available      = gnt_oh;
  assign o_engine_fifo_empty            = ~gnt_oh | {ENGINES{i_dispatch_fifo_empty}};
  assign o_dispatch_fifo_rd_en          = |(gnt_oh & i_engine_fifo_rd_en);
  assign o_dispatch_packet_read_discard = drop_pulse | gnt_done;

  assign o_engine_data_valid   = i_dispatch_data_valid;
  assign o_engine_fifo_rd_data = i_dispatch_fifo_rd_data;

  assign o_busy             = busy_q;
  assign o_dispatched_count = disp_cnt;
  assign o_dropped_count    = drop_cnt;

endmodule
